hbridge_driver: RTL
===================

Name: hbridge_driver

Overview:
- Consumes the 4-bit H-bridge command words produced by the motion blocks (turn, straight, stop) and drives the physical H-bridge pins.
- Each motor's direction pair gets shoot-through-safe dead-time on reversals.
- The enable pins are PWM-gated from a duty input, with a watchdog that coasts both motors if commands stop arriving.
- Sits between the motion-command mux and the board-level pins.

Parameters:
- DEAD_CYCLES, 50000, clocks both inputs of a channel are held 00 on a direction reversal (0.5 ms at 100 MHz); must be ≥1.
- PWM_DIV, 391, clocks per PWM counter step; 8-bit PWM period = 256*PWM_DIV clocks; must be ≥1.
- TIMEOUT_CYCLES, 50000000, clocks without cmd_valid before forced coast (500 ms); must be ≥1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd  in  4  H-bridge command: [3:2] motor A {IN1,IN2}, [1:0] motor B {IN3,IN4}. 01 = forward, 10 = reverse, 00 = coast, 11 = treated as 00. TURN_RIGHT is 0101; TURN_LEFT is 1010.
- cmd_valid  in  1  sample cmd this cycle.
- duty  in  8  PWM duty, 0..255.
- hb_in  out  4  H-bridge direction pins, same bit layout as cmd.
- en_a  out  1  motor A PWM enable.
- en_b  out  1  motor B PWM enable.
- deadtime_active  out  1  OR of both channels in DEAD state.
- timeout_flag  out  1  watchdog expired; sticky until next cmd_valid.

Behaviour:
- Reset (reset=0, async): hb_in=0000, en_a=en_b=0, deadtime_active=0, timeout_flag=0. Both channels go to COAST, all counters clear, latched duty=0.
- Input normalisation: per-channel target t = cmd pair, with 11 mapped to 00. Sampled only on a clock edge with cmd_valid=1.
- Per-channel FSM states: COAST (out 00), DRIVE (out = applied dir), DEAD (out 00, pending dir held).
  - COAST + t∈{01,10} → DRIVE; out = t on the next edge (1-cycle latency).
  - DRIVE + t==00 → COAST next edge.
  - DRIVE + t==applied → no change, no glitch.
  - DRIVE + t==opposite → DEAD. Out = 00 next edge; dead counter loads DEAD_CYCLES; pending = t.
  - DEAD: counter decrements every clock. A cmd_valid during DEAD only overwrites pending, including 00 or the original direction; the dead time is never shortened or restarted.
  - DEAD, counter reaches 0 → DRIVE with pending if nonzero, else COAST. Out is 00 for exactly DEAD_CYCLES clocks.
- PWM:
  - Free-running prescaler counts 0..PWM_DIV-1.
  - 8-bit pwm_cnt increments on prescaler wrap and wraps 255→0.
  - duty is latched only when pwm_cnt wraps to 0 (glitch-free update).
  - en_x = (pwm_cnt < latched_duty) AND channel in DRIVE, registered.
  - duty=0 gives en constantly 0; duty=255 gives 255/256 high.
  - en is forced 0 in COAST and DEAD.
- Watchdog:
  - Counter clears on every cmd_valid and otherwise increments, saturating.
  - On reaching TIMEOUT_CYCLES: timeout_flag=1 and both channels go to COAST immediately. This overrides DEAD and clears pending.
  - The next cmd_valid clears the flag and is processed normally in the same cycle.
- Simultaneous events: watchdog expiry and cmd_valid in the same cycle resolve to cmd_valid (counter cleared, no timeout).
- Channels A and B are fully independent.
- Reset asserted mid-DEAD or mid-PWM returns immediately to reset values.

Decomposition:
- Shared package (hbridge_pkg):
  - 2-bit direction codes DIR_COAST=00, DIR_FWD=01, DIR_REV=10.
  - Channel state encoding COAST/DRIVE/DEAD.
  - Command constants TURN_RIGHT=4'b0101, TURN_LEFT=4'b1010.
- One sub-module, hbridge_channel: per-motor FSM, dead counter and pending register; instantiated twice.
- Top level holds the shared PWM prescaler/counter, duty latch and watchdog.

Test Plan (DEAD_CYCLES=4, PWM_DIV=1, TIMEOUT_CYCLES=100):
- Reset then cmd=0101 with one cmd_valid → hb_in=0101 one cycle later. duty=128 gives en_a/en_b high 128 of every 256 clocks.
- From 0101, cmd=1010 → hb_in=0000 and deadtime_active=1 for exactly 4 clocks, then hb_in=1010 and deadtime_active=0.
- During that DEAD window, cmd=0000 → after 4 clocks hb_in stays 0000 and en_a=en_b=0.
- cmd=1111 → hb_in=0000. Then cmd=0100 → hb_in=0100, with only en_a toggling.
- Drive 0101, then no cmd_valid for 100 clocks → timeout_flag=1 and hb_in=0000. Next cmd_valid with 1010 → flag=0 and hb_in=1010 after 1 cycle (channels were COAST, so no dead time).
- duty changed 50→200 mid-period → en duty ratio changes only at the next pwm_cnt wrap. Async reset pulse mid-DEAD → all outputs 0 immediately.

Source files
------------

// File: rtl/hbridge_pkg.sv
// Shared H-bridge definitions: direction codes, channel FSM states and
// the canned turn commands emitted by the motion blocks.
package hbridge_pkg;

  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_FWD   = 2'b01;
  localparam logic [1:0] DIR_REV   = 2'b10;

  localparam logic [3:0] TURN_RIGHT = 4'b0101;
  localparam logic [3:0] TURN_LEFT  = 4'b1010;

  typedef enum logic [1:0] {
    CH_COAST = 2'b00,
    CH_DRIVE = 2'b01,
    CH_DEAD  = 2'b10
  } chanState;

  // Both inputs high would short the bridge leg, so 11 is read as coast.
  function automatic logic [1:0] normDir(input logic [1:0] pair);
    return (pair == 2'b11) ? DIR_COAST : pair;
  endfunction

endpackage

// File: rtl/hbridge_channel.sv
// One motor's direction FSM: inserts a fixed dead time on every reversal
// and remembers the most recent requested direction while the bridge is idle.
module hbridge_channel
  import hbridge_pkg::*;
#(
  parameter int DEAD_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmdValid,
  input  logic [1:0] target,
  input  logic       forceCoast,
  output logic [1:0] dirOut,
  output logic       driveNext,
  output logic [1:0] stateDbg
);

  localparam int CntW = $clog2(DEAD_CYCLES + 1);

  chanState        state, stateNext;
  logic [1:0]      applied, appliedNext;
  logic [1:0]      pending, pendingNext;
  logic [1:0]      tgt, deadDir;
  logic [CntW-1:0] deadCnt, deadCntNext;

  always_comb begin
    tgt         = normDir(target);
    deadDir     = cmdValid ? tgt : pending;
    stateNext   = state;
    appliedNext = applied;
    pendingNext = pending;
    deadCntNext = deadCnt;
    case (state)
      CH_COAST: begin
        if (cmdValid && tgt != DIR_COAST) begin
          stateNext   = CH_DRIVE;
          appliedNext = tgt;
        end
      end
      CH_DRIVE: begin
        if (cmdValid) begin
          if (tgt == DIR_COAST) begin
            stateNext   = CH_COAST;
            appliedNext = DIR_COAST;
          end else if (tgt != applied) begin
            stateNext   = CH_DEAD;
            appliedNext = DIR_COAST;
            pendingNext = tgt;
            deadCntNext = CntW'(DEAD_CYCLES);
          end
        end
      end
      CH_DEAD: begin
        // A command seen on the final dead clock still decides the exit direction.
        pendingNext = deadDir;
        if (deadCnt <= CntW'(1)) begin
          stateNext   = (deadDir == DIR_COAST) ? CH_COAST : CH_DRIVE;
          appliedNext = deadDir;
          pendingNext = DIR_COAST;
          deadCntNext = '0;
        end else begin
          deadCntNext = deadCnt - CntW'(1);
        end
      end
      default: begin
        stateNext   = CH_COAST;
        appliedNext = DIR_COAST;
        pendingNext = DIR_COAST;
        deadCntNext = '0;
      end
    endcase
    if (forceCoast) begin
      stateNext   = CH_COAST;
      appliedNext = DIR_COAST;
      pendingNext = DIR_COAST;
      deadCntNext = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= CH_COAST;
      applied <= DIR_COAST;
      pending <= DIR_COAST;
      deadCnt <= '0;
    end else begin
      state   <= stateNext;
      applied <= appliedNext;
      pending <= pendingNext;
      deadCnt <= deadCntNext;
    end
  end

  assign dirOut    = (state == CH_DRIVE) ? applied : DIR_COAST;
  assign driveNext = (stateNext == CH_DRIVE);
  assign stateDbg  = state;

endmodule

// File: rtl/hbridge_driver.sv
// H-bridge pin driver: two dead-timed direction channels, shared PWM enable
// gating and a command watchdog. cmd_valid is a one-way strobe with no backpressure.
module hbridge_driver
  import hbridge_pkg::*;
#(
  parameter int DEAD_CYCLES    = 50000,
  parameter int PWM_DIV        = 391,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cmd,
  input  logic       cmd_valid,
  input  logic [7:0] duty,
  output logic [3:0] hb_in,
  output logic       en_a,
  output logic       en_b,
  output logic       deadtime_active,
  output logic       timeout_flag
);

  localparam int PreW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int WdW  = $clog2(TIMEOUT_CYCLES + 1);

  logic [PreW-1:0] preCnt, preNext;
  logic [7:0]      pwmCnt, pwmNext;
  logic [7:0]      dutyLat, dutyNext;
  logic [WdW-1:0]  wdCnt, wdNext;
  logic            preWrap, expire, flagNext;
  logic            driveNextA, driveNextB;
  logic [1:0]      stateA, stateB;

  always_comb begin
    preWrap  = (preCnt == PreW'(PWM_DIV - 1));
    preNext  = preWrap ? '0 : preCnt + PreW'(1);
    pwmNext  = preWrap ? pwmCnt + 8'd1 : pwmCnt;
    // Duty only changes at a period boundary so no enable pulse is ever truncated.
    dutyNext = (preWrap && pwmCnt == 8'hFF) ? duty : dutyLat;
    expire   = !cmd_valid && (wdCnt == WdW'(TIMEOUT_CYCLES - 1));
    if (cmd_valid) begin
      wdNext = '0;
    end else if (wdCnt == WdW'(TIMEOUT_CYCLES)) begin
      wdNext = wdCnt;
    end else begin
      wdNext = wdCnt + WdW'(1);
    end
    flagNext = cmd_valid ? 1'b0 : (expire | timeout_flag);
  end

  hbridge_channel #(.DEAD_CYCLES(DEAD_CYCLES)) chanA (
    .clock      (clock),
    .reset      (reset),
    .cmdValid   (cmd_valid),
    .target     (cmd[3:2]),
    .forceCoast (expire),
    .dirOut     (hb_in[3:2]),
    .driveNext  (driveNextA),
    .stateDbg   (stateA)
  );

  hbridge_channel #(.DEAD_CYCLES(DEAD_CYCLES)) chanB (
    .clock      (clock),
    .reset      (reset),
    .cmdValid   (cmd_valid),
    .target     (cmd[1:0]),
    .forceCoast (expire),
    .dirOut     (hb_in[1:0]),
    .driveNext  (driveNextB),
    .stateDbg   (stateB)
  );

  // Enables are built from next-state values so they line up with hb_in exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      preCnt       <= '0;
      pwmCnt       <= '0;
      dutyLat      <= '0;
      wdCnt        <= '0;
      timeout_flag <= 1'b0;
      en_a         <= 1'b0;
      en_b         <= 1'b0;
    end else begin
      preCnt       <= preNext;
      pwmCnt       <= pwmNext;
      dutyLat      <= dutyNext;
      wdCnt        <= wdNext;
      timeout_flag <= flagNext;
      en_a         <= (pwmNext < dutyNext) && driveNextA;
      en_b         <= (pwmNext < dutyNext) && driveNextB;
    end
  end

  assign deadtime_active = (stateA == CH_DEAD) || (stateB == CH_DEAD);

endmodule
